// File: rtl/div_result_bcd.sv
`default_nettype none
// ============================================================================
// Module   : div_result_bcd
// Brief    : Double-dabble converter turning divider quotient/remainder into
//            packed BCD, valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module div_result_bcd #(
  parameter int N = 4,
  parameter int D = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   quotient,
  input  logic [N-1:0]   remainder,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*D-1:0] quotient_bcd,
  output logic [4*D-1:0] remainder_bcd
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int W     = 4 * D + N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N-1:0]       qbin_q;
  logic [N-1:0]       rbin_q;
  logic [4*D-1:0]     qbcd_q;
  logic [4*D-1:0]     rbcd_q;
  logic [W-1:0]       q_dd_d;
  logic [W-1:0]       r_dd_d;

  // Every digit is corrected independently before the shared shift.
  function automatic logic [4*D-1:0] dabble_adj(input logic [4*D-1:0] bcd);
    logic [4*D-1:0] res;
    res = bcd;
    for (int k = 0; k < D; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    return res;
  endfunction

  always_comb begin
    q_dd_d = {dabble_adj(qbcd_q), qbin_q} << 1;
    r_dd_d = {dabble_adj(rbcd_q), rbin_q} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      qbin_q      <= '0;
      rbin_q      <= '0;
      qbcd_q      <= '0;
      rbcd_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            qbin_q     <= quotient;
            rbin_q     <= remainder;
            qbcd_q     <= '0;
            rbcd_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          qbcd_q <= q_dd_d[W-1:N];
          qbin_q <= q_dd_d[N-1:0];
          rbcd_q <= r_dd_d[W-1:N];
          rbin_q <= r_dd_d[N-1:0];
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N - 1)) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // No same-edge accept: the next pair waits one IDLE cycle.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign quotient_bcd  = qbcd_q;
  assign remainder_bcd = rbcd_q;

endmodule
`default_nettype wire

// File: tb/tb_div_result_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_result_bcd
// Brief    : Directed self-checking bench for div_result_bcd (N=4/D=2, N=8/D=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_result_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [3:0]  a_q, a_r;
  logic [7:0]  a_qbcd, a_rbcd;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_q, b_r;
  logic [11:0] b_qbcd, b_rbcd;

  always #5 clk = ~clk;

  div_result_bcd #(.N(4), .D(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .quotient(a_q), .remainder(a_r),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .quotient_bcd(a_qbcd), .remainder_bcd(a_rbcd)
  );

  div_result_bcd #(.N(8), .D(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .quotient(b_q), .remainder(b_r),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .quotient_bcd(b_qbcd), .remainder_bcd(b_rbcd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a pair on the next edge (block must be idle), then await out_valid.
  task automatic a_conv(input logic [3:0] q, input logic [3:0] r,
                        input logic [7:0] eq, input logic [7:0] er, input string tag);
    int lat;
    a_q = q; a_r = r; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    a_q = ~q; a_r = ~r;
    chk({tag, "_busy"}, 32'(a_in_ready), 32'd0);
    lat = 0;
    while (!a_out_valid && lat < 20) begin tick(); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_q"}, 32'(a_qbcd), 32'(eq));
    chk({tag, "_r"}, 32'(a_rbcd), 32'(er));
  endtask

  task automatic a_release(input string tag);
    tick();
    chk({tag, "_rdy"}, 32'(a_in_ready), 32'd1);
    chk({tag, "_ov0"}, 32'(a_out_valid), 32'd0);
  endtask

  task automatic b_conv(input logic [7:0] q, input logic [7:0] r,
                        input logic [11:0] eq, input logic [11:0] er, input string tag);
    int lat;
    b_q = q; b_r = r; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    b_q = 8'h5a; b_r = 8'ha5;
    lat = 0;
    while (!b_out_valid && lat < 30) begin tick(); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_q"}, 32'(b_qbcd), 32'(eq));
    chk({tag, "_r"}, 32'(b_rbcd), 32'(er));
    tick();
    chk({tag, "_rdy"}, 32'(b_in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    a_in_valid = 1'b1; a_q = 4'd3; a_r = 4'd3; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_q = '0; b_r = '0; b_out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_rdy", 32'(a_in_ready), 32'd1);
    chk("rst_ov", 32'(a_out_valid), 32'd0);
    chk("rst_q", 32'(a_qbcd), 32'd0);
    chk("rst_r", 32'(a_rbcd), 32'd0);
    chk("rst_b_q", 32'(b_qbcd), 32'd0);
    rst_n = 1'b1;

    // 15/4 held across release: first edge accepts it.
    a_conv(4'd3, 4'd3, 8'h03, 8'h03, "q3r3");
    a_release("q3r3");
    a_conv(4'd1, 4'd0, 8'h01, 8'h00, "q1r0");
    a_release("q1r0");
    a_conv(4'd0, 4'd12, 8'h00, 8'h12, "q0r12");
    a_release("q0r12");
    a_conv(4'd1, 4'd4, 8'h01, 8'h04, "q1r4");

    a_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_in_valid = i[0];
      a_q = 4'(i); a_r = 4'(i);
      tick();
      chk("bp_ov", 32'(a_out_valid), 32'd1);
      chk("bp_rdy", 32'(a_in_ready), 32'd0);
      chk("bp_q", 32'(a_qbcd), 32'h01);
      chk("bp_r", 32'(a_rbcd), 32'h04);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    a_release("bp");

    a_conv(4'd15, 4'd15, 8'h15, 8'h15, "q15r15");
    a_release("q15r15");

    // Reset two shift edges into a conversion.
    a_q = 4'd15; a_r = 4'd15; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick(); tick();
    chk("mid_nonzero", 32'(a_qbcd != 8'h00), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_q", 32'(a_qbcd), 32'd0);
    chk("mid_r", 32'(a_rbcd), 32'd0);
    chk("mid_rdy", 32'(a_in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); seen = seen | a_out_valid; end
    chk("mid_no_ov", 32'(seen), 32'd0);
    a_conv(4'd9, 4'd7, 8'h09, 8'h07, "post_rst");
    a_release("post_rst");

    b_conv(8'd255, 8'd200, 12'h255, 12'h200, "b255");
    b_conv(8'd99, 8'd0, 12'h099, 12'h000, "b99");
    b_conv(8'd0, 8'd0, 12'h000, 12'h000, "b0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
